// File: rtl/fp_wire.sv
// Shared fp_unit front-end types: issue request payload, issue FSM states,
// one-hot opcode bit positions and field widths.
package fp_wire;

    localparam int unsigned FP_DATA_W   = 64;
    localparam int unsigned FP_FMT_W    = 2;
    localparam int unsigned FP_RM_W     = 3;
    localparam int unsigned FP_OP_W     = 2;
    localparam int unsigned FP_OPCODE_W = 10;
    localparam int unsigned FP_FLAGS_W  = 5;

    localparam int unsigned OPC_FMADD    = 0;
    localparam int unsigned OPC_FADD     = 1;
    localparam int unsigned OPC_FSUB     = 2;
    localparam int unsigned OPC_FMUL     = 3;
    localparam int unsigned OPC_FDIV     = 4;
    localparam int unsigned OPC_FSQRT    = 5;
    localparam int unsigned OPC_FCMP     = 6;
    localparam int unsigned OPC_FCVT_F2F = 7;
    localparam int unsigned OPC_FCVT_I2F = 8;
    localparam int unsigned OPC_FCVT_F2I = 9;

    typedef struct packed {
        logic [FP_DATA_W-1:0]   data1;
        logic [FP_DATA_W-1:0]   data2;
        logic [FP_DATA_W-1:0]   data3;
        logic [FP_FMT_W-1:0]    fmt;
        logic [FP_RM_W-1:0]     rm;
        logic [FP_OP_W-1:0]     op;
        logic [FP_OPCODE_W-1:0] opcode;
    } fp_issue_req_type;

    typedef enum logic [1:0] {
        FP_ISSUE_IDLE  = 2'd0,
        FP_ISSUE_ISSUE = 2'd1,
        FP_ISSUE_WAIT  = 2'd2,
        FP_ISSUE_RESP  = 2'd3
    } fp_issue_state_type;

    // Exactly one opcode bit set; zero or multi-hot is rejected without issuing.
    function automatic logic opcode_legal(input logic [FP_OPCODE_W-1:0] opc);
        return (opc != '0) && ((opc & (opc - FP_OPCODE_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/fp_issue_fifo.sv
// In-order request FIFO for the fp issue sequencer; synchronous, power-of-two depth.
module fp_issue_fifo
    import fp_wire::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  fp_issue_req_type din,
    output fp_issue_req_type dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fp_issue_req_type r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr];

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fp_issue_sequencer.sv
// Buffers fp operation requests and issues them one at a time to fp_unit,
// returning result, flags and an in-order sequence tag with a completion watchdog.
module fp_issue_sequencer
    import fp_wire::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [FP_DATA_W-1:0]   req_data1,
    input  logic [FP_DATA_W-1:0]   req_data2,
    input  logic [FP_DATA_W-1:0]   req_data3,
    input  logic [FP_FMT_W-1:0]    req_fmt,
    input  logic [FP_RM_W-1:0]     req_rm,
    input  logic [FP_OP_W-1:0]     req_op,
    input  logic [FP_OPCODE_W-1:0] req_opcode,

    output logic [FP_DATA_W-1:0]   exe_data1,
    output logic [FP_DATA_W-1:0]   exe_data2,
    output logic [FP_DATA_W-1:0]   exe_data3,
    output logic [FP_FMT_W-1:0]    exe_fmt,
    output logic [FP_RM_W-1:0]     exe_rm,
    output logic [FP_OP_W-1:0]     exe_op,
    output logic [FP_OPCODE_W-1:0] exe_opcode,
    output logic                   exe_enable,
    input  logic [FP_DATA_W-1:0]   exe_result,
    input  logic [FP_FLAGS_W-1:0]  exe_flags,
    input  logic                   exe_ready,

    output logic                   rsp_valid,
    output logic [FP_DATA_W-1:0]   rsp_result,
    output logic [FP_FLAGS_W-1:0]  rsp_flags,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

    fp_issue_state_type     r_state;
    fp_issue_req_type       r_hold;
    logic [TAG_W-1:0]       r_tag_cnt;
    logic [WDOG_W-1:0]      r_wdog;
    logic                   r_exe_enable;
    logic                   r_rsp_valid;
    logic [FP_DATA_W-1:0]   r_rsp_result;
    logic [FP_FLAGS_W-1:0]  r_rsp_flags;
    logic [TAG_W-1:0]       r_rsp_tag;
    logic                   r_rsp_err;

    fp_issue_req_type       w_req;
    fp_issue_req_type       w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;

    always_comb begin
        w_req        = '0;
        w_req.data1  = req_data1;
        w_req.data2  = req_data2;
        w_req.data3  = req_data3;
        w_req.fmt    = req_fmt;
        w_req.rm     = req_rm;
        w_req.op     = req_op;
        w_req.opcode = req_opcode;
    end

    assign w_push = req_valid && !w_full;
    assign w_pop  = (r_state == FP_ISSUE_IDLE) && !w_empty;

    fp_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_req),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Issue FSM: one operation outstanding, operands held in r_hold until the next pop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= FP_ISSUE_IDLE;
            r_hold       <= '0;
            r_tag_cnt    <= '0;
            r_wdog       <= '0;
            r_exe_enable <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_exe_enable <= 1'b0;
            r_rsp_valid  <= 1'b0;
            case (r_state)
                FP_ISSUE_IDLE: begin
                    if (!w_empty) begin
                        r_hold    <= w_head;
                        r_rsp_tag <= r_tag_cnt;
                        r_tag_cnt <= r_tag_cnt + TAG_W'(1);
                        if (opcode_legal(w_head.opcode)) begin
                            r_state <= FP_ISSUE_ISSUE;
                        end else begin
                            r_rsp_valid  <= 1'b1;
                            r_rsp_err    <= 1'b1;
                            r_rsp_result <= '0;
                            r_rsp_flags  <= '0;
                            r_state      <= FP_ISSUE_RESP;
                        end
                    end
                end
                FP_ISSUE_ISSUE: begin
                    r_exe_enable <= 1'b1;
                    r_wdog       <= '0;
                    r_state      <= FP_ISSUE_WAIT;
                end
                FP_ISSUE_WAIT: begin
                    // Completion wins over a watchdog expiry landing on the same edge.
                    if (exe_ready) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_err    <= 1'b0;
                        r_rsp_result <= exe_result;
                        r_rsp_flags  <= exe_flags;
                        r_state      <= FP_ISSUE_RESP;
                    end else if (r_wdog == WDOG_W'(TIMEOUT - 1)) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_err    <= 1'b1;
                        r_rsp_result <= '0;
                        r_rsp_flags  <= '0;
                        r_state      <= FP_ISSUE_RESP;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                FP_ISSUE_RESP: begin
                    r_state <= FP_ISSUE_IDLE;
                end
                default: begin
                    r_state <= FP_ISSUE_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = !w_full;
    assign busy       = !w_empty || (r_state != FP_ISSUE_IDLE);

    assign exe_data1  = r_hold.data1;
    assign exe_data2  = r_hold.data2;
    assign exe_data3  = r_hold.data3;
    assign exe_fmt    = r_hold.fmt;
    assign exe_rm     = r_hold.rm;
    assign exe_op     = r_hold.op;
    assign exe_opcode = r_hold.opcode;
    assign exe_enable = r_exe_enable;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_fp_issue_sequencer.sv
// Randomised and directed bench for fp_issue_sequencer against a timeline model
// of the issue/response rules, with a stub fp_unit responder.
module tb_fp_issue_sequencer;
    import fp_wire::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 2;
    localparam int unsigned TIMEOUT = 20;
    localparam int          TAG_MOD = 1 << TAG_W;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_data1, req_data2, req_data3;
    logic [1:0]  req_fmt;
    logic [2:0]  req_rm;
    logic [1:0]  req_op;
    logic [9:0]  req_opcode;
    logic [63:0] exe_data1, exe_data2, exe_data3;
    logic [1:0]  exe_fmt;
    logic [2:0]  exe_rm;
    logic [1:0]  exe_op;
    logic [9:0]  exe_opcode;
    logic        exe_enable;
    logic [63:0] exe_result;
    logic [4:0]  exe_flags;
    logic        exe_ready;
    logic        rsp_valid;
    logic [63:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic        rsp_err;
    logic        busy;

    fp_issue_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
        .req_fmt(req_fmt), .req_rm(req_rm), .req_op(req_op), .req_opcode(req_opcode),
        .exe_data1(exe_data1), .exe_data2(exe_data2), .exe_data3(exe_data3),
        .exe_fmt(exe_fmt), .exe_rm(exe_rm), .exe_op(exe_op), .exe_opcode(exe_opcode),
        .exe_enable(exe_enable), .exe_result(exe_result), .exe_flags(exe_flags),
        .exe_ready(exe_ready),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] d1, d2, d3;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [1:0]  op;
        logic [9:0]  opc;
    } req_t;

    typedef struct {
        int          cyc;
        logic [63:0] res;
        logic [4:0]  flg;
        int          tag;
        logic        err;
    } rsp_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // responder controls
    int          resp_mode = 0;   // 0: ready rdy_delay cycles after enable, 1: random
    int          rdy_delay = -1;  // -1: never
    logic [63:0] dir_res   = '0;
    logic [4:0]  dir_flg   = '0;
    bit          stray     = 1'b0;

    // model state
    req_t        m_q[$];
    req_t        m_hold;
    bit          m_live     = 1'b0;
    bit          m_inflight = 1'b0;
    int          m_en_cyc   = -1;
    int          m_rsp_cyc  = -1;
    int          m_pop_edge = 0;
    int          m_tag      = 0;
    int          m_rtag     = 0;
    logic [63:0] m_res      = '0;
    logic [4:0]  m_flg      = '0;
    logic        m_err      = 1'b0;

    rsp_t rsp_log[$];
    int   en_log[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare DUT against the model for this cycle, then advance the model across the next edge.
    always @(negedge clock) begin : compare
        int   qn;
        req_t cur;
        if (m_live) begin
            check("req_ready", 64'(req_ready), 64'(m_q.size() < DEPTH));
            check("busy", 64'(busy), 64'((m_q.size() != 0) || m_inflight || (cyc == m_rsp_cyc)));
            check("exe_enable", 64'(exe_enable), 64'(cyc == m_en_cyc));
            check("rsp_valid", 64'(rsp_valid), 64'(cyc == m_rsp_cyc));
            if (exe_enable) en_log.push_back(cyc);
            if (rsp_valid) rsp_log.push_back('{cyc, rsp_result, rsp_flags, int'(rsp_tag), rsp_err});
            if (cyc == m_rsp_cyc) begin
                check("rsp_result", rsp_result, m_res);
                check("rsp_flags", 64'(rsp_flags), 64'(m_flg));
                check("rsp_tag", 64'(rsp_tag), 64'(m_rtag));
                check("rsp_err", 64'(rsp_err), 64'(m_err));
            end
            if (m_inflight && cyc >= m_en_cyc) begin
                check("exe_data1", exe_data1, m_hold.d1);
                check("exe_data2", exe_data2, m_hold.d2);
                check("exe_data3", exe_data3, m_hold.d3);
                check("exe_ctrl", 64'({exe_fmt, exe_rm, exe_op, exe_opcode}),
                      64'({m_hold.fmt, m_hold.rm, m_hold.op, m_hold.opc}));
            end
        end
        if (!reset) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_en_cyc   = -1;
            m_rsp_cyc  = -1;
            m_pop_edge = cyc + 2;
            m_tag      = 0;
            m_live     = 1'b1;
        end else if (m_live) begin
            qn = m_q.size();
            if (m_inflight && cyc >= m_en_cyc) begin
                if (exe_ready) begin
                    m_rsp_cyc = cyc + 1; m_res = exe_result; m_flg = exe_flags; m_err = 1'b0;
                    m_inflight = 1'b0; m_pop_edge = cyc + 3;
                end else if (cyc + 1 == m_en_cyc + int'(TIMEOUT)) begin
                    m_rsp_cyc = cyc + 1; m_res = '0; m_flg = '0; m_err = 1'b1;
                    m_inflight = 1'b0; m_pop_edge = cyc + 3;
                end
            end else if (!m_inflight && cyc + 1 >= m_pop_edge && qn > 0) begin
                m_hold = m_q.pop_front();
                m_rtag = m_tag;
                m_tag  = (m_tag + 1) % TAG_MOD;
                if ($countones(m_hold.opc) == 1) begin
                    m_inflight = 1'b1;
                    m_en_cyc   = cyc + 2;
                end else begin
                    m_rsp_cyc = cyc + 1; m_res = '0; m_flg = '0; m_err = 1'b1;
                    m_pop_edge = cyc + 3;
                end
            end
            if (req_valid && qn < int'(DEPTH)) begin
                cur = '{req_data1, req_data2, req_data3, req_fmt, req_rm, req_op, req_opcode};
                m_q.push_back(cur);
            end
        end
    end

    // Stub fp_unit: drives garbage results except when it signals completion.
    initial begin : responder
        int cd;
        cd = -1;
        exe_ready = 1'b0; exe_result = '0; exe_flags = '0;
        forever begin
            @(posedge clock); #1;
            exe_ready  = 1'b0;
            exe_result = {$urandom, $urandom};
            exe_flags  = 5'($urandom);
            if (exe_enable) cd = rdy_delay;
            if (resp_mode == 0) begin
                if (cd == 0) begin
                    exe_ready = 1'b1; exe_result = dir_res; exe_flags = dir_flg;
                end
            end else begin
                exe_ready = ($urandom_range(0, 3) == 0);
            end
            if (stray) exe_ready = 1'b1;
            if (cd >= 0) cd--;
        end
    end

    function automatic req_t rand_req(input bit allow_bad);
        req_t r;
        r.d1  = {$urandom, $urandom};
        r.d2  = {$urandom, $urandom};
        r.d3  = {$urandom, $urandom};
        r.fmt = 2'($urandom_range(0, 1));
        r.rm  = 3'($urandom);
        r.op  = 2'($urandom);
        if (allow_bad && $urandom_range(0, 4) == 0) r.opc = 10'($urandom);
        else r.opc = 10'(1) << $urandom_range(0, 9);
        return r;
    endfunction

    task automatic drive(input req_t r, input logic v);
        req_data1 = r.d1; req_data2 = r.d2; req_data3 = r.d3;
        req_fmt = r.fmt; req_rm = r.rm; req_op = r.op; req_opcode = r.opc;
        req_valid = v;
    endtask

    task automatic push(input req_t r, output int acc_edge);
        int k;
        k = 0;
        drive(r, 1'b1);
        @(negedge clock);
        while (!req_ready && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL push: req_ready stayed %0b, required 1", req_ready);
            acc_edge = -1;
            @(posedge clock); #1;
        end else begin
            @(posedge clock); #1;
            acc_edge = cyc;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int k;
        k = 0;
        while (rsp_log.size() < n && k < budget) begin
            @(posedge clock); #1;
            k++;
        end
        checks++;
        if (rsp_log.size() < n) begin
            errors++;
            $display("FAIL wait_rsp: got %0d responses, required %0d", rsp_log.size(), n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    initial begin : main
        req_t r;
        int   e, n0, e0;
        int   exp_tags[5];
        exp_tags = '{0, 1, 2, 3, 0};
        drive(rand_req(1'b0), 1'b0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // reset state
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst exe_enable", 64'(exe_enable), 64'd0);
        check("rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst rsp_tag", 64'(rsp_tag), 64'd0);
        check("rst rsp_result", rsp_result, 64'd0);
        check("rst exe_data1", exe_data1, 64'd0);
        check("rst exe_opcode", 64'(exe_opcode), 64'd0);
        repeat (2) @(posedge clock); #1;

        // single fadd 1.0 + 2.0
        resp_mode = 0; rdy_delay = 3; dir_res = 64'h4040_0000; dir_flg = '0;
        r = rand_req(1'b0);
        r.d1 = 64'h3F80_0000; r.d2 = 64'h4000_0000; r.fmt = 2'd0; r.rm = 3'd0;
        r.opc = 10'(1) << OPC_FADD;
        n0 = rsp_log.size(); e0 = en_log.size();
        push(r, e);
        wait_rsp(n0 + 1, 50);
        repeat (3) @(posedge clock); #1;
        check("fadd en_count", 64'(en_log.size() - e0), 64'd1);
        if (en_log.size() > e0) check("fadd en_cycle", 64'(en_log[e0]), 64'(e + 2));
        if (rsp_log.size() > n0) begin
            check("fadd rsp_cycle", 64'(rsp_log[n0].cyc), 64'(e + 6));
            check("fadd tag", 64'(rsp_log[n0].tag), 64'd0);
            check("fadd result", rsp_log[n0].res, 64'h4040_0000);
            check("fadd err", 64'(rsp_log[n0].err), 64'd0);
        end

        // fill past DEPTH with a slow fp_unit; tags wrap at 2 bits
        do_reset();
        rdy_delay = 10;
        n0 = rsp_log.size();
        for (int i = 0; i < int'(DEPTH) + 1; i++) push(rand_req(1'b0), e);
        check("fill req_ready", 64'(req_ready), 64'd0);
        wait_rsp(n0 + int'(DEPTH) + 1, 400);
        for (int i = 0; i < int'(DEPTH) + 1; i++)
            if (rsp_log.size() > n0 + i) check("fill tag", 64'(rsp_log[n0 + i].tag), 64'(exp_tags[i]));

        // illegal opcode followed by a legal one
        rdy_delay = 2;
        n0 = rsp_log.size(); e0 = en_log.size();
        r = rand_req(1'b0);
        r.opc = (10'(1) << OPC_FADD) | (10'(1) << OPC_FSUB);
        push(r, e);
        push(rand_req(1'b0), e);
        wait_rsp(n0 + 2, 100);
        check("illegal en_count", 64'(en_log.size() - e0), 64'd1);
        if (rsp_log.size() >= n0 + 2) begin
            check("illegal err", 64'(rsp_log[n0].err), 64'd1);
            check("illegal result", rsp_log[n0].res, 64'd0);
            check("illegal tag", 64'(rsp_log[n0].tag), 64'd1);
            check("after illegal tag", 64'(rsp_log[n0 + 1].tag), 64'd2);
            check("after illegal err", 64'(rsp_log[n0 + 1].err), 64'd0);
        end

        // watchdog expiry, then the queued op issues normally
        rdy_delay = -1;
        n0 = rsp_log.size(); e0 = en_log.size();
        push(rand_req(1'b0), e);
        push(rand_req(1'b0), e);
        wait_rsp(n0 + 1, 100);
        rdy_delay = 2;
        wait_rsp(n0 + 2, 100);
        if (rsp_log.size() >= n0 + 2 && en_log.size() >= e0 + 2) begin
            check("timeout err", 64'(rsp_log[n0].err), 64'd1);
            check("timeout latency", 64'(rsp_log[n0].cyc - en_log[e0]), 64'(TIMEOUT));
            check("post-timeout err", 64'(rsp_log[n0 + 1].err), 64'd0);
            check("post-timeout gap", 64'(en_log[e0 + 1] - rsp_log[n0].cyc), 64'd3);
        end

        // reset while waiting, then a stray completion
        rdy_delay = -1;
        e0 = en_log.size();
        push(rand_req(1'b0), e);
        for (int k = 0; k < 20 && en_log.size() == e0; k++) begin
            @(posedge clock); #1;
        end
        repeat (3) @(posedge clock); #1;
        n0 = rsp_log.size();
        do_reset();
        stray = 1'b1;
        repeat (3) @(posedge clock); #1;
        stray = 1'b0;
        repeat (2) @(posedge clock); #1;
        check("reset no rsp", 64'(rsp_log.size()), 64'(n0));
        check("reset busy", 64'(busy), 64'd0);
        rdy_delay = 1;
        push(rand_req(1'b0), e);
        wait_rsp(n0 + 1, 50);
        if (rsp_log.size() > n0) check("reset tag restart", 64'(rsp_log[n0].tag), 64'd0);

        // random traffic with a random fp_unit
        resp_mode = 1;
        for (int i = 0; i < 500; i++) begin
            drive(rand_req(1'b1), $urandom_range(0, 2) != 0);
            @(posedge clock); #1;
        end
        req_valid = 1'b0;
        for (int k = 0; k < 3000 && busy; k++) begin
            @(posedge clock); #1;
        end
        check("drain busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clock); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : global_limit
        #900000;
        $display("FAIL global_limit: simulation did not finish, errors=%0d", errors + 1);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "time limit");
    end

endmodule
